// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command sequencer owning accumulator and flags around a combinational ALU
module alu_op_sequencer #(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] acc,
  output logic             flag_z,
  output logic             flag_c,
  output logic             err,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);
  state_t state, state_nx;
  logic [WIDTH-1:0] acc_nx, opnd, opnd_nx, rsp_data_nx;
  logic [2:0] sel, sel_nx;
  logic [3:0] cnt, cnt_nx, op_off;
  logic flag_z_nx, flag_c_nx, err_nx, rsp_valid_nx;
  assign cmd_ready = state == IDLE;
  assign busy      = !cmd_ready;
  assign alu_a     = state == EXEC ? acc  : '0;
  assign alu_b     = state == EXEC ? opnd : '0;
  assign alu_op    = state == EXEC ? sel  : 3'd0;
  // ADD..XOR opcodes 2..6 map directly onto ALU selects 0..4
  assign op_off    = cmd_op - 4'd2;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      opnd      <= '0;
      sel       <= '0;
      cnt       <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      err       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      opnd      <= opnd_nx;
      sel       <= sel_nx;
      cnt       <= cnt_nx;
      flag_z    <= flag_z_nx;
      flag_c    <= flag_c_nx;
      err       <= err_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_data  <= rsp_data_nx;
    end
  end
  always_comb begin
    state_nx     = state;
    acc_nx       = acc;
    opnd_nx      = opnd;
    sel_nx       = sel;
    cnt_nx       = cnt;
    flag_z_nx    = flag_z;
    flag_c_nx    = flag_c;
    err_nx       = err;
    rsp_valid_nx = rsp_valid;
    rsp_data_nx  = rsp_data;
    if (state == IDLE && cmd_valid) begin
      if (cmd_op == 4'd1) begin
        acc_nx = cmd_data;
      end else if (cmd_op >= 4'd2 && cmd_op <= 4'd6) begin
        opnd_nx  = cmd_data;
        sel_nx   = op_off[2:0];
        cnt_nx   = LAT_M1;
        state_nx = EXEC;
      end else if (cmd_op == 4'd7) begin
        rsp_data_nx  = acc;
        rsp_valid_nx = 1'b1;
        state_nx     = RESP;
      end else if (cmd_op[3]) begin
        err_nx = 1'b1;
      end
    end
    if (state == EXEC) begin
      cnt_nx = cnt - 4'd1;
      if (cnt == 4'd0) begin
        acc_nx    = alu_y;
        flag_z_nx = alu_y == '0;
        flag_c_nx = sel <= 3'd1 ? alu_c : 1'b0;
        cnt_nx    = 4'd0;
        state_nx  = IDLE;
      end
    end
    if (state == RESP && rsp_ready) begin
      rsp_valid_nx = 1'b0;
      state_nx     = IDLE;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: two sequencers (ALU_LAT 1 and 3) with an ALU stand-in, checked against an arithmetic model
module tb_alu_op_sequencer;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic         cmd_valid [2];
  logic         cmd_ready [2];
  logic [3:0]   cmd_op    [2];
  logic [W-1:0] cmd_data  [2];
  logic [W-1:0] alu_a     [2];
  logic [W-1:0] alu_b     [2];
  logic [2:0]   alu_op    [2];
  logic [W-1:0] alu_y     [2];
  logic         alu_c     [2];
  logic         rsp_valid [2];
  logic         rsp_ready [2];
  logic [W-1:0] rsp_data  [2];
  logic [W-1:0] acc       [2];
  logic         flag_z    [2];
  logic         flag_c    [2];
  logic         err       [2];
  logic         busy      [2];
  int lat [2] = '{1, 3};
  int m_acc [2], m_z [2], m_c [2], m_err [2];
  int errors = 0;
  int checks = 0;

  function automatic logic [W:0] alu_f(logic [2:0] s, logic [W-1:0] a, logic [W-1:0] b);
    return s == 3'd0 ? {1'b0, a} + {1'b0, b} :
           s == 3'd1 ? {1'b0, a} - {1'b0, b} :
           s == 3'd2 ? {1'b0, a & b} :
           s == 3'd3 ? {1'b0, a | b} :
           s == 3'd4 ? {1'b0, a ^ b} : '0;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_op_sequencer #(.WIDTH(W), .ALU_LAT(g == 0 ? 1 : 3)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_op(cmd_op[g]), .cmd_data(cmd_data[g]),
      .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_op(alu_op[g]), .alu_y(alu_y[g]), .alu_c(alu_c[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_data(rsp_data[g]),
      .acc(acc[g]), .flag_z(flag_z[g]), .flag_c(flag_c[g]), .err(err[g]), .busy(busy[g])
    );
    assign {alu_c[g], alu_y[g]} = alu_f(alu_op[g], alu_a[g], alu_b[g]);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_regs(int k, string tag);
    chk({tag, ".acc"}, acc[k], m_acc[k]);
    chk({tag, ".z"}, flag_z[k], m_z[k]);
    chk({tag, ".c"}, flag_c[k], m_c[k]);
    chk({tag, ".err"}, err[k], m_err[k]);
    chk({tag, ".ready"}, cmd_ready[k], 1);
    chk({tag, ".busy"}, busy[k], 0);
    chk({tag, ".rsp_valid"}, rsp_valid[k], 0);
    chk({tag, ".alu_abo"}, {alu_a[k], alu_b[k], alu_op[k]}, 0);
  endtask

  // Model of one command: arithmetic on plain ints, ALU ops finish exactly lat cycles after accept
  task automatic issue(int k, logic [3:0] op, logic [7:0] d, int stall, string tag);
    int a, r;
    chk({tag, ".ready_in"}, cmd_ready[k], 1);
    cmd_valid[k] = 1'b1; cmd_op[k] = op; cmd_data[k] = d;
    @(negedge clk);
    cmd_valid[k] = 1'b0; cmd_op[k] = 4'($urandom); cmd_data[k] = 8'($urandom);
    if (op >= 2 && op <= 6) begin
      a = m_acc[k];
      for (int i = 0; i < lat[k]; i++) begin
        chk({tag, ".exec_busy"}, {busy[k], cmd_ready[k]}, 2'b10);
        chk({tag, ".exec_a"}, alu_a[k], a);
        chk({tag, ".exec_b"}, alu_b[k], d);
        chk({tag, ".exec_op"}, alu_op[k], op - 2);
        chk({tag, ".exec_acc"}, acc[k], a);
        @(negedge clk);
      end
      case (op)
        2: begin r = a + d; m_c[k] = r > 255; end
        3: begin r = a - d; m_c[k] = a < d; end
        4: begin r = a & d; m_c[k] = 0; end
        5: begin r = a | d; m_c[k] = 0; end
        default: begin r = a ^ d; m_c[k] = 0; end
      endcase
      m_acc[k] = r & 255;
      m_z[k] = m_acc[k] == 0;
    end else if (op == 7) begin
      cmd_valid[k] = 1'b1; cmd_op[k] = 4'd1; cmd_data[k] = 8'(~m_acc[k]);
      for (int i = 0; i <= stall; i++) begin
        rsp_ready[k] = i == stall;
        chk({tag, ".rsp_valid"}, rsp_valid[k], 1);
        chk({tag, ".rsp_data"}, rsp_data[k], m_acc[k]);
        chk({tag, ".rsp_ready_out"}, cmd_ready[k], 0);
        @(negedge clk);
      end
      rsp_ready[k] = 1'b0; cmd_valid[k] = 1'b0;
      chk({tag, ".rsp_hold"}, rsp_data[k], m_acc[k]);
    end else if (op == 1) m_acc[k] = d;
    else if (op >= 8) m_err[k] = 1;
    idle_regs(k, tag);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 0; cmd_op[k] = 0; cmd_data[k] = 0; rsp_ready[k] = 0;
      m_acc[k] = 0; m_z[k] = 0; m_c[k] = 0; m_err[k] = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_regs(0, "reset0");
    idle_regs(1, "reset1");
    chk("reset.rsp_data", {rsp_data[0], rsp_data[1]}, 0);
    issue(0, 4'd1, 8'h12, 0, "lda12");
    issue(0, 4'd2, 8'h34, 0, "add34");
    issue(0, 4'd7, 8'h00, 0, "out46");
    chk("out46.val", rsp_data[0], 8'h46);
    issue(0, 4'd1, 8'hFF, 0, "ldaff");
    issue(0, 4'd2, 8'h01, 0, "wrap");
    chk("wrap.zc", {acc[0], flag_z[0], flag_c[0]}, 10'b0000000011);
    issue(0, 4'd6, 8'h00, 0, "xor0");
    chk("xor0.zc", {flag_z[0], flag_c[0]}, 2'b10);
    issue(1, 4'd1, 8'h0F, 0, "lda0f");
    issue(1, 4'd4, 8'h3C, 0, "and3c");
    chk("and3c.val", acc[1], 8'h0C);
    issue(0, 4'd1, 8'h77, 0, "lda77");
    issue(0, 4'd7, 8'h00, 4, "out_stall");
    issue(0, 4'd0, 8'h99, 0, "nop");
    issue(1, 4'd1, 8'h5A, 0, "lda5a");
    issue(1, 4'hA, 8'h21, 0, "illegal");
    chk("illegal.err", err[1], 1);
    issue(1, 4'd3, 8'h5B, 0, "sub_borrow");
    chk("sub_borrow.vc", {acc[1], flag_c[1]}, {8'hFF, 1'b1});
    for (int n = 0; n < 80; n++)
      issue(n % 2, 4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 3), "rnd");
    cmd_valid[1] = 1'b1; cmd_op[1] = 4'd3; cmd_data[1] = 8'h11;
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    chk("midexec.busy", busy[1], 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_z[k] = 0; m_c[k] = 0; m_err[k] = 0;
    end
    idle_regs(1, "midexec_rst");
    idle_regs(0, "midexec_rst0");
    issue(1, 4'd5, 8'hC3, 0, "post_rst_or");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
